// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, ready-handshaked imem port and IF/ID register.
// Ports: clk/reset (async high); stall_f, flush_d from hazard unit; pcsrc_d/pcbranch_d, jump_d
// redirect requests from D; imem_req/imem_addr/imem_rdata/imem_ready memory handshake;
// instr_d/pcplus4_d/valid_d IF/ID contents; redirect_pending while a redirect waits on a fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        flush_d,
  input  logic        pcsrc_d,
  input  logic [31:0] pcbranch_d,
  input  logic        jump_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        redirect_pending
);
  typedef enum logic {RUN, PEND} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, pend_q, pend_d, ir_q, ir_d, pp4_q, pp4_d;
  logic vld_q, vld_d, fire, redir;
  logic [31:0] target, pc_plus4;
  logic unused_ok;
  assign unused_ok = ^pcbranch_d[1:0];
  assign imem_req = !reset;
  assign imem_addr = pc_q;
  assign instr_d = ir_q;
  assign pcplus4_d = pp4_q;
  assign valid_d = vld_q;
  assign redirect_pending = (state_q == PEND);
  assign fire = imem_req && imem_ready;
  assign redir = (jump_d || pcsrc_d) && vld_q && !stall_f;
  assign target = jump_d ? {pp4_q[31:28], ir_q[25:0], 2'b00} : {pcbranch_d[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;
  // IF/ID defaults to a bubble; only a clean in-order fetch in RUN loads a real word.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_q;
    ir_d = 32'h0;
    pp4_d = 32'h0;
    vld_d = 1'b0;
    if (stall_f) begin
      ir_d = ir_q;
      pp4_d = pp4_q;
      vld_d = vld_q;
    end
    if (state_q == RUN) begin
      if (!stall_f) begin
        if (fire) begin
          if (redir) pc_d = target;
          else begin
            pc_d = pc_plus4;
            ir_d = imem_rdata;
            pp4_d = pc_plus4;
            vld_d = 1'b1;
          end
        end else if (redir) begin
          // address must stay stable until the outstanding fetch finishes
          pend_d = target;
          state_d = PEND;
        end
      end
    end else if (fire) begin
      pc_d = pend_q;
      state_d = RUN;
    end
    if (flush_d) begin
      ir_d = 32'h0;
      pp4_d = 32'h0;
      vld_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      pend_q <= 32'h0;
      ir_q <= 32'h0;
      pp4_q <= 32'h0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_q <= pend_d;
      ir_q <= ir_d;
      pp4_q <= pp4_d;
      vld_q <= vld_d;
    end
  end
endmodule
